hdmi_line_upscaler: RTL and testbench

Single-clock video upscaler between the PPU pixel stream and the HDMI encoder. It generates the HDMI raster counters and tells the pixel source when to start each frame. Input pixels arrive at PPU rate, qualified by a clock-enable strobe. Each input line is captured into a ping-pong line buffer and replayed as two output lines, with nearest-neighbour horizontal stretch. Output RGB goes to the TMDS encoder.

---
 rtl/hdmi_line_upscaler_if.sv | 21 ++
 rtl/hdmi_line_upscaler.sv | 170 +++++++++++++++++
 tb/tb_hdmi_line_upscaler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_line_upscaler_if.sv
// Pixel-source and HDMI-side signals of the line upscaler, bundled for port connection.
// The upscaler uses the slave view; the pixel source / encoder side uses master.
interface hdmi_line_upscaler_if;
  logic        p_en;
  logic [23:0] rgb_p;
  logic [1:0]  aux;
  logic        new_frame;
  logic [9:0]  hx;
  logic [9:0]  hy;
  logic [23:0] rgb_h;

  modport master (
    output p_en, rgb_p, aux,
    input  new_frame, hx, hy, rgb_h
  );

  modport slave (
    input  p_en, rgb_p, aux,
    output new_frame, hx, hy, rgb_h
  );
endinterface

// File: rtl/hdmi_line_upscaler.sv
// Line-doubling upscaler: captures PPU lines into a ping-pong buffer and replays each
// as two HDMI lines with nearest-neighbour horizontal stretch. Requires IPIXEL_LATENCY >= 1.
module hdmi_line_upscaler #(
  parameter int ISCREEN_WIDTH  = 256,
  parameter int ISCREEN_HEIGHT = 240,
  parameter int IFRAME_WIDTH   = 341,
  parameter int IFRAME_HEIGHT  = 262,
  parameter int OSCREEN_WIDTH  = 720,
  parameter int OSCREEN_HEIGHT = 480,
  parameter int OFRAME_WIDTH   = 858,
  parameter int OFRAME_HEIGHT  = 525,
  parameter int IPIXEL_LATENCY = 1
) (
  input logic                 clk_h,
  input logic                 rst_h,
  hdmi_line_upscaler_if.slave bus
);

  // Lead raster runs this many clocks ahead: one for the buffer read, one for the output register.
  localparam int LEAD   = 2;
  localparam int ADDR_W = (ISCREEN_WIDTH > 1) ? $clog2(ISCREEN_WIDTH) : 1;

  localparam logic [9:0]  IW_C   = 10'(ISCREEN_WIDTH);
  localparam logic [9:0]  IH_C   = 10'(ISCREEN_HEIGHT);
  localparam logic [9:0]  IFW_C  = 10'(IFRAME_WIDTH);
  localparam logic [9:0]  IFH_C  = 10'(IFRAME_HEIGHT);
  localparam logic [9:0]  OW_C   = 10'(OSCREEN_WIDTH);
  localparam logic [9:0]  OH_C   = 10'(OSCREEN_HEIGHT);
  localparam logic [9:0]  OFW_C  = 10'(OFRAME_WIDTH);
  localparam logic [9:0]  OFH_C  = 10'(OFRAME_HEIGHT);
  localparam logic [11:0] IW_A   = 12'(ISCREEN_WIDTH);
  localparam logic [11:0] OW_A   = 12'(OSCREEN_WIDTH);
  localparam logic [9:0]  CX_RST = 10'(LEAD);
  localparam logic [11:0] ACC_RST = 12'((LEAD * ISCREEN_WIDTH) % OSCREEN_WIDTH);
  localparam logic [9:0]  IX_RST  = 10'((LEAD * ISCREEN_WIDTH) / OSCREEN_WIDTH);
  // After the new_frame strobe, the counters point at the position of the next strobe.
  localparam logic [9:0]  PX_LOAD = 10'((IPIXEL_LATENCY <= 1) ? 0 : IFRAME_WIDTH - IPIXEL_LATENCY + 1);
  localparam logic [9:0]  PY_LOAD = 10'((IPIXEL_LATENCY <= 1) ? 0 : IFRAME_HEIGHT - 1);

  logic [9:0]  r_hx, r_hy;
  logic [9:0]  r_cx, r_cy;
  logic [11:0] r_acc;
  logic [9:0]  r_ix;
  logic        r_arm;
  logic        r_run;
  logic [9:0]  r_px, r_py;
  logic        r_row0;
  logic [23:0] r_buf0 [ISCREEN_WIDTH];
  logic [23:0] r_buf1 [ISCREEN_WIDTH];
  logic [23:0] r_rd;
  logic        r_act1, r_scan1, r_vis1;
  logic [23:0] r_rgb;

  logic        w_at_pos;
  logic        w_nf;
  logic        w_wr;
  logic        w_lead_act;
  logic [11:0] w_acc_sum;
  logic        w_aux_unused;

  assign w_aux_unused = bus.aux[1];
  assign w_at_pos     = (r_hx == 10'd0) && (r_hy == OFH_C - 10'd2);
  assign w_nf         = bus.p_en && (r_arm || w_at_pos);
  assign w_wr         = bus.p_en && !w_nf && r_run && (r_px < IW_C) && (r_py < IH_C);
  assign w_lead_act   = (r_cx < OW_C) && (r_cy < OH_C);
  assign w_acc_sum    = r_acc + IW_A;

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_hx <= '0;
      r_hy <= '0;
    end else if (r_hx == OFW_C - 10'd1) begin
      r_hx <= '0;
      r_hy <= (r_hy == OFH_C - 10'd1) ? 10'd0 : r_hy + 10'd1;
    end else begin
      r_hx <= r_hx + 10'd1;
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_cx  <= CX_RST;
      r_cy  <= '0;
      r_acc <= ACC_RST;
      r_ix  <= IX_RST;
    end else if (r_cx == OFW_C - 10'd1) begin
      r_cx  <= '0;
      r_cy  <= (r_cy == OFH_C - 10'd1) ? 10'd0 : r_cy + 10'd1;
      r_acc <= '0;
      r_ix  <= '0;
    end else begin
      r_cx <= r_cx + 10'd1;
      // Upscaling only, so at most one wrap of the accumulator per clock.
      if (w_acc_sum >= OW_A) begin
        r_acc <= w_acc_sum - OW_A;
        r_ix  <= r_ix + 10'd1;
      end else begin
        r_acc <= w_acc_sum;
      end
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_arm <= 1'b0;
    end else begin
      r_arm <= (r_arm || w_at_pos) && !bus.p_en;
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_run  <= 1'b0;
      r_px   <= '0;
      r_py   <= '0;
      r_row0 <= 1'b0;
    end else if (bus.p_en) begin
      if (w_nf) begin
        r_run <= 1'b1;
        r_px  <= PX_LOAD;
        r_py  <= PY_LOAD;
      end else if (r_run) begin
        if (r_px == IFW_C - 10'd1) begin
          r_px <= '0;
          r_py <= (r_py == IFH_C - 10'd1) ? 10'd0 : r_py + 10'd1;
        end else begin
          r_px <= r_px + 10'd1;
        end
      end
      if (w_wr && (r_px == IW_C - 10'd1) && (r_py == 10'd0)) begin
        r_row0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_h) begin
    if (w_wr) begin
      if (r_py[0]) r_buf1[r_px[ADDR_W-1:0]] <= bus.rgb_p;
      else         r_buf0[r_px[ADDR_W-1:0]] <= bus.rgb_p;
    end
  end

  // Output row pair 2k,2k+1 shows input row k, held in buffer k[0] = cy[1].
  always_ff @(posedge clk_h) begin
    if (w_lead_act) begin
      r_rd <= r_cy[1] ? r_buf1[r_ix[ADDR_W-1:0]] : r_buf0[r_ix[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      r_act1  <= 1'b0;
      r_scan1 <= 1'b0;
      r_vis1  <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_act1  <= w_lead_act;
      r_scan1 <= bus.aux[0] && r_cy[0];
      r_vis1  <= r_row0;
      if (r_act1 && r_vis1) r_rgb <= r_scan1 ? ((r_rd >> 1) & 24'h7F7F7F) : r_rd;
      else                  r_rgb <= '0;
    end
  end

  assign bus.new_frame = w_nf;
  assign bus.hx        = r_hx;
  assign bus.hy        = r_hy;
  assign bus.rgb_h     = r_rgb;

endmodule

// File: tb/tb_hdmi_line_upscaler.sv
// Directed bench for hdmi_line_upscaler on a reduced raster, checked every cycle against
// an arithmetic model of the raster, the source's line buffers and the scaling rules.
module tb_hdmi_line_upscaler;
  localparam int IW = 25, IH = 24, IFW = 33, IFH = 26;
  localparam int OW = 72, OH = 48, OFW = 86, OFH = 53;

  logic clk_h = 1'b0;
  logic rst_h = 1'b0;
  always #5 clk_h = ~clk_h;

  hdmi_line_upscaler_if bus ();

  hdmi_line_upscaler #(
    .ISCREEN_WIDTH(IW), .ISCREEN_HEIGHT(IH), .IFRAME_WIDTH(IFW), .IFRAME_HEIGHT(IFH),
    .OSCREEN_WIDTH(OW), .OSCREEN_HEIGHT(OH), .OFRAME_WIDTH(OFW), .OFRAME_HEIGHT(OFH),
    .IPIXEL_LATENCY(1)
  ) dut (
    .clk_h(clk_h),
    .rst_h(rst_h),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int          rx, ry;
  bit          arm, started, row0done;
  int          sx, sy;
  int          pat;
  int          pacc;
  int          nf_cnt;
  logic [23:0] mbuf [2][IW];

  function automatic logic [23:0] src_pix(int x, int y);
    case (pat)
      0:       return (x == 0 || x == IW - 1 || y == 0 || y == IH - 1) ? 24'hFFFFFF : 24'h204080;
      1:       return 24'(x) << 16;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(int x, int y);
    logic [23:0] v;
    if (x >= OW || y >= OH || !row0done) return 24'h0;
    v = mbuf[(y / 2) % 2][(x * IW) / OW];
    if (bus.aux[0] && (y % 2 == 1)) v = (v >> 1) & 24'h7F7F7F;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (model hx=%0d hy=%0d)", name, act, exp, rx, ry);
    end
  endtask

  task automatic model_reset();
    rx = 0; ry = 0; arm = 0; started = 0; row0done = 0; nf_cnt = 0; sx = 0; sy = 0;
  endtask

  // One clock: advance the raster model, compare outputs, drive the next strobe, update source model.
  task automatic cycle();
    bit pen, at, expnf;
    @(posedge clk_h);
    #1;
    rx++;
    if (rx == OFW) begin
      rx = 0;
      ry++;
      if (ry == OFH) begin
        ry = 0;
        chk("nf_per_frame", nf_cnt, 1);
        nf_cnt = 0;
      end
    end
    chk("hx", bus.hx, rx);
    chk("hy", bus.hy, ry);
    chk("rgb_h", bus.rgb_h, exp_rgb(rx, ry));
    pacc += 10;
    pen = (pacc >= 52);
    if (pen) pacc -= 52;
    bus.p_en  = pen;
    bus.rgb_p = src_pix(sx, sy);
    #1;
    at    = (rx == 0) && (ry == OFH - 2);
    expnf = pen && (arm || at);
    chk("new_frame", bus.new_frame, expnf);
    arm = (arm || at) && !pen;
    if (pen) begin
      if (expnf) begin
        nf_cnt++;
        started = 1;
        sx = 0;
        sy = 0;
      end else if (started) begin
        if (sx < IW && sy < IH) begin
          mbuf[sy % 2][sx] = bus.rgb_p;
          if (sx == IW - 1 && sy == 0) row0done = 1;
        end
        sx++;
        if (sx == IFW) begin
          sx = 0;
          sy++;
          if (sy == IFH) sy = 0;
        end
      end
    end
  endtask

  task automatic run_to(int x, int y);
    int n = 0;
    while (!(rx == x && ry == y) && n < 10000) begin
      cycle();
      n++;
    end
    if (n >= 10000) begin
      total++;
      bad++;
      $display("FAIL run_to_timeout: did not reach hx=%0d hy=%0d", x, y);
    end
  endtask

  initial begin
    bus.p_en  = 1'b0;
    bus.rgb_p = 24'h0;
    bus.aux   = 2'b00;
    pat  = 0;
    pacc = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < IW; i++) mbuf[b][i] = 24'h0;
    model_reset();

    repeat (3) @(negedge clk_h);
    chk("rst_hx", bus.hx, 0);
    chk("rst_hy", bus.hy, 0);
    chk("rst_rgb", bus.rgb_h, 0);
    chk("rst_nf", bus.new_frame, 0);
    rst_h = 1'b1;

    run_to(85, 0);
    chk("hx_last", bus.hx, 85);
    cycle();
    chk("hx_wrap", bus.hx, 0);
    chk("hy_step", bus.hy, 1);
    run_to(10, 10);
    chk("first_frame_blank", bus.rgb_h, 24'h0);
    run_to(85, 52);
    cycle();
    chk("hy_wrap", bus.hy, 0);

    // Frame 2: border pattern
    chk("border_0_0", bus.rgb_h, 24'hFFFFFF);
    run_to(71, 1);
    chk("border_71_1", bus.rgb_h, 24'hFFFFFF);
    run_to(2, 10);
    chk("border_col2", bus.rgb_h, 24'hFFFFFF);
    run_to(3, 10);
    chk("inner_col3", bus.rgb_h, 24'h204080);
    run_to(69, 10);
    chk("inner_col69", bus.rgb_h, 24'h204080);
    run_to(70, 10);
    chk("border_col70", bus.rgb_h, 24'hFFFFFF);
    run_to(40, 46);
    chk("border_row46", bus.rgb_h, 24'hFFFFFF);
    run_to(40, 47);
    chk("border_row47", bus.rgb_h, 24'hFFFFFF);
    run_to(0, 50);
    pat = 1;

    // Frame 3: column-index ramp
    run_to(3, 10);
    chk("map_hx3", bus.rgb_h, 24'h010000);
    run_to(71, 10);
    chk("map_hx71", bus.rgb_h, 24'h180000);
    run_to(72, 10);
    chk("map_hx72_blank", bus.rgb_h, 24'h0);
    run_to(3, 48);
    chk("map_hy48_blank", bus.rgb_h, 24'h0);
    run_to(0, 50);
    pat = 2;
    bus.aux = 2'b01;

    // Frame 4: scanline effect
    run_to(5, 4);
    chk("scan_even", bus.rgb_h, 24'hFFFFFF);
    run_to(5, 5);
    chk("scan_odd", bus.rgb_h, 24'h7F7F7F);
    run_to(0, 50);
    bus.aux = 2'b10;

    // Frame 5: aux[1] ignored, then reset mid-frame
    run_to(5, 5);
    chk("aux1_odd", bus.rgb_h, 24'hFFFFFF);
    run_to(5, 20);
    rst_h = 1'b0;
    #1;
    chk("midrst_hx", bus.hx, 0);
    chk("midrst_hy", bus.hy, 0);
    chk("midrst_rgb", bus.rgb_h, 0);
    chk("midrst_nf", bus.new_frame, 0);
    bus.p_en = 1'b0;
    repeat (3) @(negedge clk_h);
    model_reset();
    rst_h = 1'b1;

    run_to(10, 10);
    chk("post_rst_blank", bus.rgb_h, 24'h0);
    run_to(85, 52);
    cycle();
    run_to(10, 10);
    chk("post_rst_restored", bus.rgb_h, 24'hFFFFFF);
    run_to(10, 11);
    chk("post_rst_odd", bus.rgb_h, 24'hFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
